// File: rtl/clkgen_ctrl.sv
// Programmable clock divider with a ready/valid divisor handshake and glitch-free stop.
// Define CLKGEN_CTRL_TICK_EN to generate tick_o on each clk_o rising edge; otherwise tick_o is 0.
module clkgen_ctrl #(
  parameter int CLKIN   = 50,
  parameter int CLKOUT  = 12,
  parameter int DIV_W   = 16,
  parameter int DIV_RST = CLKIN / (2 * CLKOUT) - 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic [DIV_W-1:0] cur_div_o
);

  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] w_cur_nxt;
  logic [DIV_W-1:0] r_pend_div;
  logic [DIV_W-1:0] w_pend_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_clk;
  logic             w_clk_nxt;
  logic             w_accept;
  logic             w_at_top;

  assign div_ready_o = (r_state == IDLE) || (r_state == RUN);
  assign w_accept    = div_valid_i && div_ready_o;
  assign w_at_top    = (r_cnt == r_cur_div);

  assign clk_o     = r_clk;
  assign busy_o    = r_busy;
  assign cur_div_o = r_cur_div;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cur_div  <= DIV_W'(DIV_RST);
      r_pend_div <= '0;
      r_busy     <= 1'b0;
      r_clk      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur_div  <= w_cur_nxt;
      r_pend_div <= w_pend_nxt;
      r_busy     <= w_busy_nxt;
      r_clk      <= w_clk_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur_div;
    w_pend_nxt  = r_pend_div;
    w_busy_nxt  = r_busy;
    w_clk_nxt   = r_clk;
    case (r_state)
      IDLE: begin
        w_clk_nxt = 1'b0;
        w_cnt_nxt = '0;
        if (w_accept) w_cur_nxt = div_i;
        // Preload the counter to its top so clk_o rises on the first RUN cycle.
        if (en_i) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = w_accept ? div_i : r_cur_div;
        end
      end
      RUN, PEND: begin
        if (w_at_top) begin
          w_cnt_nxt = '0;
          w_clk_nxt = ~r_clk;
          // A pending divisor only takes over at a rising edge, so the new high phase is full length.
          if (!r_clk && (r_state == PEND)) begin
            w_cur_nxt   = r_pend_div;
            w_busy_nxt  = 1'b0;
            w_state_nxt = RUN;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        if (w_accept) begin
          w_pend_nxt  = div_i;
          w_busy_nxt  = 1'b1;
          w_state_nxt = PEND;
        end
        if (!en_i) w_state_nxt = STOP;
      end
      STOP: begin
        // Hold any high phase to its natural end before parking low.
        if (!r_clk || w_at_top) begin
          w_clk_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          if (r_busy) begin
            w_cur_nxt  = r_pend_div;
            w_busy_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef CLKGEN_CTRL_TICK_EN
  logic r_tick;
  logic w_rise;

  assign w_rise = ((r_state == RUN) || (r_state == PEND)) && w_at_top && !r_clk;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_tick <= 1'b0;
    else       r_tick <= w_rise;
  end

  assign tick_o = r_tick;
`else
  assign tick_o = 1'b0;
`endif

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Testbench for clkgen_ctrl: directed literal checks plus randomized stimulus
// compared every cycle against a phase-based reference model.
module tb_clkgen_ctrl;

`ifdef CLKGEN_CTRL_TICK_EN
  localparam bit TICK_EN = 1'b1;
`else
  localparam bit TICK_EN = 1'b0;
`endif
  localparam int EXP_RST = 50 / (2 * 12) - 1;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] div;
  logic        divValid;
  logic        divReady;
  logic        clkOut;
  logic        tick;
  logic        busy;
  logic [15:0] curDiv;

  int nCompared;
  int nMismatched;

  clkgen_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .div_i      (div),
    .div_valid_i(divValid),
    .div_ready_o(divReady),
    .clk_o      (clkOut),
    .tick_o     (tick),
    .busy_o     (busy),
    .cur_div_o  (curDiv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = parked low, 1 = running, 2 = stopping.
  // mLeft counts clock edges remaining until the next clk_o toggle.
  bit          mOk;
  int          mMode;
  bit          mClk;
  bit          mTick;
  bit          mPv;
  int          mLeft;
  logic [15:0] mCur;
  logic [15:0] mPend;

  function automatic bit mReady();
    return (mMode == 0) || (mMode == 1 && !mPv);
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      mOk = 1'b1; mMode = 0; mClk = 1'b0; mTick = 1'b0; mPv = 1'b0;
      mLeft = 0; mCur = 16'(EXP_RST); mPend = '0;
    end else if (mOk) begin
      acc   = divValid && mReady();
      mTick = 1'b0;
      case (mMode)
        0: begin
          if (acc) mCur = div;
          if (en) begin mMode = 1; mLeft = 1; end
        end
        1: begin
          if (mLeft == 1) begin
            if (!mClk) begin
              if (mPv) begin mCur = mPend; mPv = 1'b0; end
              mClk = 1'b1; mTick = 1'b1;
            end else begin
              mClk = 1'b0;
            end
            mLeft = int'(mCur) + 1;
          end else begin
            mLeft--;
          end
          if (acc) begin mPv = 1'b1; mPend = div; end
          if (!en) mMode = 2;
        end
        default: begin
          if (!mClk || mLeft == 1) begin
            mClk = 1'b0; mMode = 0;
            if (mPv) begin mCur = mPend; mPv = 1'b0; end
          end else begin
            mLeft--;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (mOk) begin
      checkOutput("cmp.clk",   clkOut,   mClk);
      checkOutput("cmp.tick",  tick,     TICK_EN ? mTick : 1'b0);
      checkOutput("cmp.busy",  busy,     mPv);
      checkOutput("cmp.ready", divReady, mReady());
      checkOutput("cmp.cur",   curDiv,   mCur);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      divValid = ($urandom_range(0, 3) == 0);
      div      = 16'($urandom_range(0, 5));
      step(1);
    end
  endtask

  initial begin
    int patA[8]  = '{0, 1, 1, 0, 0, 1, 1, 0};
    int patB[11] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    int patD[5]  = '{0, 1, 0, 1, 0};
    int rises;
    int ticks;
    bit prevClk;

    nCompared = 0; nMismatched = 0;
    rst = 1'b1; en = 1'b0; divValid = 1'b0; div = '0;
    step(2);
    checkOutput("rst.clk",   clkOut,   0);
    checkOutput("rst.cur",   curDiv,   1);
    checkOutput("rst.busy",  busy,     0);
    checkOutput("rst.ready", divReady, 1);
    checkOutput("rst.tick",  tick,     0);

    // Default divisor: period 4, 50% duty, clk_o rises the cycle after RUN entry.
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      checkOutput("A.clk",  clkOut, patA[i]);
      checkOutput("A.mclk", mClk,   patA[i]);
    end
    checkOutput("A.cur", curDiv, 1);

    // Divisor change offered mid-high-phase takes effect at the next rising edge.
    step(2);
    checkOutput("B.clkhi", clkOut, 1);
    div = 16'd3; divValid = 1'b1;
    step(1);
    divValid = 1'b0;
    checkOutput("B.ready", divReady, 0);
    checkOutput("B.busy",  busy,     1);
    checkOutput("B.cur",   curDiv,   1);
    for (int i = 0; i < 11; i++) begin
      step(1);
      checkOutput("B.clk",  clkOut, patB[i]);
      checkOutput("B.mclk", mClk,   patB[i]);
      if (i == 2) begin
        checkOutput("B.busy0", busy,   0);
        checkOutput("B.cur3",  curDiv, 3);
      end
    end

    // Disable one cycle after a rise: high phase still lasts 4 cycles.
    en = 1'b0;
    step(1);
    checkOutput("C.clk1",  clkOut,   1);
    checkOutput("C.ready", divReady, 0);
    step(1);
    checkOutput("C.clk2",  clkOut,   1);
    step(1);
    checkOutput("C.clk3",  clkOut,   1);
    step(1);
    checkOutput("C.clk0",  clkOut,   0);
    checkOutput("C.idle",  divReady, 1);
    checkOutput("C.mclk0", mClk,     0);

    // Divisor 0 loaded while parked, then period 2.
    div = 16'd0; divValid = 1'b1;
    step(1);
    checkOutput("D.cur0", curDiv, 0);
    divValid = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      checkOutput("D.clk",  clkOut, patD[i]);
      checkOutput("D.mclk", mClk,   patD[i]);
    end

    // Reset during a pending change with clk_o high.
    div = 16'd2; divValid = 1'b1;
    step(1);
    divValid = 1'b0;
    checkOutput("E.clkhi", clkOut,   1);
    checkOutput("E.busy",  busy,     1);
    checkOutput("E.ready", divReady, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("E.clk",  clkOut, 0);
    checkOutput("E.cur",  curDiv, 1);
    checkOutput("E.busy0", busy,  0);
    checkOutput("E.tick", tick,   0);

    // Tick pulses against clk_o rising edges over 200 cycles.
    rises = 0; ticks = 0; prevClk = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (clkOut && !prevClk) rises++;
      if (tick) ticks++;
      prevClk = clkOut;
    end
    checkOutput("F.rises", rises, 50);
    checkOutput("F.ticks", ticks, TICK_EN ? 50 : 0);

    applyStimulus(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
